// File: rtl/ps2_keymap.sv
// rtl/ps2_keymap.sv - PS/2 Set-2 scan-code decoder mapping a key table to make/break/held outputs
module ps2_keymap #(
    parameter int                 NKEYS          = 8,
    parameter logic [9*NKEYS-1:0] KEY_TABLE      = {9'h023, 9'h01C, 9'h01B, 9'h01D,
                                                    9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                 REPEAT_EN      = 0,
    parameter int                 PREFIX_TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_ready,
    input  logic [7:0]       data_in,
    output logic [NKEYS-1:0] make_pulse,
    output logic [NKEYS-1:0] break_pulse,
    output logic [NKEYS-1:0] held,
    output logic             any_held,
    output logic             pause_pulse,
    output logic             unknown_pulse
);

    localparam int               TW       = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [NKEYS-1:0] REP_MASK = (REPEAT_EN != 0) ? '1 : '0;

    typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_skip_cnt;
    logic [TW-1:0]    r_to_cnt;

    logic             w_is_resp;
    logic             w_timeout;
    logic             w_final;
    logic             w_ext;
    logic             w_brk;
    logic             w_pause;
    logic [NKEYS-1:0] w_match;
    logic [NKEYS-1:0] w_held_next;

    assign w_is_resp = data_in inside {8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE};
    assign w_timeout = !data_ready && (r_state != S_IDLE) && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (data_ready) begin
            if (r_state == S_SKIP) begin
                w_next_state = (r_skip_cnt == 3'd1) ? S_IDLE : S_SKIP;
            end else if (data_in == 8'hE0) begin
                w_next_state = S_E0;
            end else if (data_in == 8'hF0) begin
                case (r_state)
                    S_IDLE:  w_next_state = S_F0;
                    S_E0:    w_next_state = S_E0F0;
                    default: w_next_state = r_state;
                endcase
            end else if (data_in == 8'hE1) begin
                w_next_state = S_SKIP;
            end else begin
                w_next_state = S_IDLE;
            end
        end else if (w_timeout) begin
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        w_final = data_ready && (r_state != S_SKIP) && !w_is_resp &&
                  !(data_in inside {8'hE0, 8'hF0, 8'hE1});
        w_ext   = (r_state == S_E0) || (r_state == S_E0F0);
        w_brk   = (r_state == S_F0) || (r_state == S_E0F0);
        w_pause = data_ready && (r_state == S_SKIP) && (r_skip_cnt == 3'd1);
        w_match = '0;
        for (int i = 0; i < NKEYS; i++) begin
            w_match[i] = (KEY_TABLE[9*i +: 9] == {w_ext, data_in});
        end
        w_held_next = held;
        if (w_final) begin
            w_held_next = w_brk ? (held & ~w_match) : (held | w_match);
        end
    end

    // Skip counter swallows the fixed 7 trailing bytes of the Pause sequence
    always_ff @(posedge clk) begin
        if (rst || w_timeout) begin
            r_skip_cnt <= 3'd0;
        end else if (data_ready) begin
            if (r_state == S_SKIP) begin
                r_skip_cnt <= r_skip_cnt - 3'd1;
            end else if (data_in == 8'hE1) begin
                r_skip_cnt <= 3'd7;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || data_ready || (r_state == S_IDLE) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            make_pulse    <= '0;
            break_pulse   <= '0;
            held          <= '0;
            any_held      <= 1'b0;
            pause_pulse   <= 1'b0;
            unknown_pulse <= 1'b0;
        end else begin
            make_pulse    <= '0;
            break_pulse   <= '0;
            unknown_pulse <= 1'b0;
            pause_pulse   <= w_pause;
            held          <= w_held_next;
            any_held      <= |w_held_next;
            if (w_final) begin
                if (w_brk) begin
                    break_pulse <= w_match;
                end else begin
                    make_pulse    <= w_match & (REP_MASK | ~held);
                    unknown_pulse <= ~|w_match;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap.sv
// tb/tb_ps2_keymap.sv - self-checking bench for ps2_keymap with a byte-level reference model
module tb_ps2_keymap;

    localparam int PT = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] mk0, bk0, hd0, mk1, bk1, hd1;
    logic       ah0, pz0, un0, ah1, pz1, un1;

    always #5 clk = ~clk;

    ps2_keymap #(.NKEYS(8), .REPEAT_EN(0), .PREFIX_TIMEOUT(PT)) dut0 (
        .clk(clk), .rst(rst), .data_ready(data_ready), .data_in(data_in),
        .make_pulse(mk0), .break_pulse(bk0), .held(hd0), .any_held(ah0),
        .pause_pulse(pz0), .unknown_pulse(un0));

    ps2_keymap #(.NKEYS(8), .REPEAT_EN(1), .PREFIX_TIMEOUT(PT)) dut1 (
        .clk(clk), .rst(rst), .data_ready(data_ready), .data_in(data_in),
        .make_pulse(mk1), .break_pulse(bk1), .held(hd1), .any_held(ah1),
        .pause_pulse(pz1), .unknown_pulse(un1));

    int checks = 0;
    int errors = 0;

    logic [8:0] tbl [8];
    logic [7:0] e_mk0, e_mk1, e_bk, e_hd;
    logic       e_pz, e_un;
    bit         m_ext, m_brk;
    int         m_skip, m_idle;

    logic [26:0] obs0, obs1, exp0, exp1;
    assign obs0 = {mk0, bk0, hd0, ah0, pz0, un0};
    assign obs1 = {mk1, bk1, hd1, ah1, pz1, un1};
    assign exp0 = {e_mk0, e_bk, e_hd, |e_hd, e_pz, e_un};
    assign exp1 = {e_mk1, e_bk, e_hd, |e_hd, e_pz, e_un};

    // Reference: pending-prefix flags plus a remaining-bytes count for Pause
    task automatic model_step(input bit dr, input logic [7:0] b, input bit rs);
        bit hit;
        e_mk0 = '0; e_mk1 = '0; e_bk = '0; e_pz = 1'b0; e_un = 1'b0;
        if (rs) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0; e_hd = '0;
            return;
        end
        if (dr) begin
            m_idle = 0;
            if (m_skip > 0) begin
                m_skip--;
                if (m_skip == 0) e_pz = 1'b1;
            end else if (b == 8'hE0) begin
                m_ext = 1; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else if (b == 8'hE1) begin
                m_skip = 7; m_ext = 0; m_brk = 0;
            end else if (b inside {8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE}) begin
                m_ext = 0; m_brk = 0;
            end else begin
                hit = 0;
                for (int k = 0; k < 8; k++) begin
                    if (tbl[k] == {m_ext, b}) begin
                        hit = 1;
                        if (m_brk) begin
                            e_bk[k] = 1'b1; e_hd[k] = 1'b0;
                        end else begin
                            e_mk1[k] = 1'b1;
                            if (!e_hd[k]) e_mk0[k] = 1'b1;
                            e_hd[k] = 1'b1;
                        end
                    end
                end
                if (!hit && !m_brk) e_un = 1'b1;
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk || m_skip > 0) begin
            m_idle++;
            if (m_idle == PT) begin
                m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
            end
        end
    endtask

    task automatic tick(input bit dr, input logic [7:0] b, input bit rs);
        @(negedge clk);
        data_ready = dr; data_in = b; rst = rs;
        model_step(dr, b, rs);
        @(posedge clk);
        #1;
        data_ready = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        tick(1, 8'h75, 1);
        tick(1, 8'h1D, 1);
        checks++;
        if (obs0 !== 27'd0) begin
            errors++; $display("FAIL reset_dut0 got=%h want=0", obs0);
        end
        checks++;
        if (obs1 !== 27'd0) begin
            errors++; $display("FAIL reset_dut1 got=%h want=0", obs1);
        end
    endtask

    task automatic test_up_key();
        tick(1, 8'hE0, 0);
        checks++;
        if (obs0 !== 27'd0) begin
            errors++; $display("FAIL up_prefix got=%h want=0", obs0);
        end
        tick(1, 8'h75, 0);
        checks++;
        if (mk0 !== 8'h01 || hd0 !== 8'h01 || ah0 !== 1'b1 || mk1 !== 8'h01) begin
            errors++; $display("FAIL up_make mk0=%h hd0=%h ah0=%b mk1=%h want 01 01 1 01", mk0, hd0, ah0, mk1);
        end
        tick(0, 8'h00, 0);
        checks++;
        if (mk0 !== 8'h00 || hd0 !== 8'h01) begin
            errors++; $display("FAIL up_pulse_width mk0=%h hd0=%h want 00 01", mk0, hd0);
        end
        tick(1, 8'hE0, 0);
        tick(1, 8'hF0, 0);
        tick(1, 8'h75, 0);
        checks++;
        if (bk0 !== 8'h01 || hd0 !== 8'h00 || ah0 !== 1'b0 || bk1 !== 8'h01) begin
            errors++; $display("FAIL up_break bk0=%h hd0=%h ah0=%b bk1=%h want 01 00 0 01", bk0, hd0, ah0, bk1);
        end
    endtask

    task automatic test_repeat();
        int n0, n1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'h1D, 0);
            n0 += int'(mk0[4]);
            n1 += int'(mk1[4]);
        end
        checks++;
        if (n0 != 1) begin
            errors++; $display("FAIL repeat_off got=%0d pulses want=1", n0);
        end
        checks++;
        if (n1 != 3) begin
            errors++; $display("FAIL repeat_on got=%0d pulses want=3", n1);
        end
        tick(1, 8'hF0, 0);
        tick(1, 8'h1D, 0);
        checks++;
        if (bk0 !== 8'h10 || hd0 !== 8'h00) begin
            errors++; $display("FAIL repeat_release bk0=%h hd0=%h want 10 00", bk0, hd0);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        int npz;
        logic other;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        tick(1, 8'h1D, 0);
        npz = 0; other = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1, seq[i], 0);
            npz += int'(pz0);
            other |= (|mk0) | (|bk0) | un0;
        end
        checks++;
        if (pz0 !== 1'b1 || npz != 1) begin
            errors++; $display("FAIL pause_pulse last=%b count=%0d want 1 1", pz0, npz);
        end
        checks++;
        if (other !== 1'b0 || hd0 !== 8'h10) begin
            errors++; $display("FAIL pause_side other=%b hd0=%h want 0 10", other, hd0);
        end
        tick(0, 8'h00, 0);
        tick(1, 8'hF0, 0);
        tick(1, 8'h1D, 0);
    endtask

    task automatic test_timeout();
        tick(1, 8'hE0, 0);
        repeat (PT) tick(0, 8'h00, 0);
        tick(1, 8'h75, 0);
        checks++;
        if (un0 !== 1'b1 || hd0[3] !== 1'b0 || mk0 !== 8'h00) begin
            errors++; $display("FAIL timeout_expire un0=%b hd0=%h mk0=%h want 1 x0 00", un0, hd0, mk0);
        end
        tick(1, 8'hE0, 0);
        repeat (PT - 1) tick(0, 8'h00, 0);
        tick(1, 8'h75, 0);
        checks++;
        if (mk0 !== 8'h01 || un0 !== 1'b0) begin
            errors++; $display("FAIL timeout_edge mk0=%h un0=%b want 01 0", mk0, un0);
        end
        tick(1, 8'hE0, 0);
        tick(1, 8'hF0, 0);
        tick(1, 8'h75, 0);
    endtask

    task automatic test_response();
        tick(1, 8'hE0, 0);
        tick(1, 8'hFA, 0);
        checks++;
        if ({mk0, bk0, pz0, un0} !== 18'd0) begin
            errors++; $display("FAIL resp_quiet got=%h want=0", {mk0, bk0, pz0, un0});
        end
        tick(1, 8'h75, 0);
        checks++;
        if (un0 !== 1'b1 || mk0 !== 8'h00) begin
            errors++; $display("FAIL resp_then_75 un0=%b mk0=%h want 1 00", un0, mk0);
        end
        tick(1, 8'hE0, 0);
        tick(1, 8'h75, 0);
        tick(1, 8'h6B, 1);
        checks++;
        if (obs0 !== 27'd0 || obs1 !== 27'd0) begin
            errors++; $display("FAIL reset_override dut0=%h dut1=%h want 0 0", obs0, obs1);
        end
    endtask

    task automatic test_multi();
        tick(1, 8'hE0, 0);
        tick(1, 8'h6B, 0);
        tick(1, 8'hE0, 0);
        tick(1, 8'h75, 0);
        checks++;
        if (hd0 !== 8'h05) begin
            errors++; $display("FAIL multi_held got=%h want=05", hd0);
        end
        tick(1, 8'hE0, 0);
        tick(1, 8'hF0, 0);
        tick(1, 8'h6B, 0);
        checks++;
        if (hd0 !== 8'h01 || ah0 !== 1'b1 || bk0 !== 8'h04) begin
            errors++; $display("FAIL multi_release hd0=%h ah0=%b bk0=%h want 01 1 04", hd0, ah0, bk0);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit dr, rs;
        int gap;
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 149) == 0);
            dr = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 19))
                0, 1, 2:    b = 8'hE0;
                3, 4:       b = 8'hF0;
                5:          b = 8'hE1;
                6:          b = 8'hFA;
                7:          b = 8'hAA;
                8:          b = 8'($urandom);
                default:    b = tbl[$urandom_range(0, 7)][7:0];
            endcase
            gap = ($urandom_range(0, 39) == 0) ? PT - 1 + int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                tick(0, 8'h00, 0);
                checks++;
                if (obs0 !== exp0) begin
                    errors++; $display("FAIL rand_gap_dut0 iter=%0d got=%h want=%h", i, obs0, exp0);
                end
            end
            tick(dr, b, rs);
            checks++;
            if (obs0 !== exp0) begin
                errors++; $display("FAIL rand_dut0 iter=%0d byte=%h got=%h want=%h", i, b, obs0, exp0);
            end
            checks++;
            if (obs1 !== exp1) begin
                errors++; $display("FAIL rand_dut1 iter=%0d byte=%h got=%h want=%h", i, b, obs1, exp1);
            end
        end
    endtask

    initial begin
        tbl = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h01D, 9'h01B, 9'h01C, 9'h023};
        m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
        e_mk0 = '0; e_mk1 = '0; e_bk = '0; e_hd = '0; e_pz = 1'b0; e_un = 1'b0;
        test_reset();
        test_up_key();
        test_repeat();
        test_pause();
        test_timeout();
        test_response();
        test_multi();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keymap.md
PS2_KEYMAP -- requirements
Module: ps2_keymap

Interface
REQ-001 SHALL have parameter NKEYS, default 8, number of mapped keys (1..32).
REQ-002 SHALL have parameter KEY_TABLE, width 9*NKEYS, default {ext=0,23h; 0,1Ch; 0,1Bh; 0,1Dh; 1,74h; 1,6Bh; 1,72h; 1,75h}: entry i = bits [9i+8:9i] = {ext, code}, so entry 0 = E0 75 (up) and entry 7 = 23 (D).
REQ-003 SHALL have parameter REPEAT_EN, default 0: 0 suppresses typematic repeat makes, 1 pulses on every make.
REQ-004 SHALL have parameter PREFIX_TIMEOUT, default 50000, idle cycles before a partial sequence is discarded (>=2).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port data_ready  input  1  one-cycle strobe, data_in valid.
REQ-008 SHALL have port data_in  input  8  received PS/2 Set-2 byte.
REQ-009 SHALL have port make_pulse  output  NKEYS  one-cycle press event per key.
REQ-010 SHALL have port break_pulse  output  NKEYS  one-cycle release event per key.
REQ-011 SHALL have port held  output  NKEYS  level, key currently down.
REQ-012 SHALL have port any_held  output  1  OR-reduction of held, registered with held.
REQ-013 SHALL have port pause_pulse  output  1  one-cycle Pause-key event.
REQ-014 SHALL have port unknown_pulse  output  1  one-cycle event, complete make code matches no entry.

Function
REQ-015 SHALL decode with states IDLE, E0, F0, E0F0, SKIP; bytes act only when data_ready=1.
REQ-016 SHALL transition on E0h from IDLE/E0/F0/E0F0 to E0 (restart, prior prefix discarded).
REQ-017 SHALL transition on F0h: IDLE->F0, E0->E0F0, F0 and E0F0 unchanged.
REQ-018 SHALL on E1h from any non-SKIP state enter SKIP with skip counter=7; each byte in SKIP decrements; the byte taking counter to 0 returns to IDLE and asserts pause_pulse next cycle.
REQ-019 SHALL treat AAh, EEh, FAh, FCh, FEh in any non-SKIP state as controller responses: no pulses, state->IDLE.
REQ-020 SHALL treat any other byte in a non-SKIP state as final code: ext=1 if state in {E0,E0F0}, brk=1 if state in {F0,E0F0}; state->IDLE.
REQ-021 SHALL on final make compare {ext,code} against all entries in parallel; every matching i sets held[i]; make_pulse[i]=1 if REPEAT_EN=1 or held[i] was 0.
REQ-022 SHALL on final break clear held[i] and assert break_pulse[i] for every matching i, regardless of prior held.
REQ-023 SHALL assert unknown_pulse on a final make matching no entry; never on unmatched break.
REQ-024 SHALL register all pulses and held updates on the clock edge following the data_ready cycle of the final byte (latency 1); pulses last exactly 1 cycle.
REQ-025 SHALL count idle cycles while state != IDLE, clearing on each data_ready; on reaching PREFIX_TIMEOUT return to IDLE without pulses.
REQ-026 SHALL give data_ready priority over timeout when both occur in one cycle: byte processed in current state.
REQ-027 SHALL keep held unchanged on timeout, response bytes and E1 sequences.
REQ-028 SHALL produce no outputs from combinational paths of data_in.

Reset
REQ-029 SHALL on rst=1 at a clock edge set state=IDLE, skip and timeout counters=0, held=0, any_held=0, all pulses=0; rst overrides data_ready same cycle.
REQ-030 SHALL discard any partial sequence on reset; bytes following reset are decoded from IDLE.

Verification
REQ-031 SHALL verify bytes E0,75 -> make_pulse=01h one cycle after 75, held[0]=1, any_held=1; then E0,F0,75 -> break_pulse=01h, held=00h.
REQ-032 SHALL verify REPEAT_EN=0: 1D,1D,1D -> single make_pulse[4]; REPEAT_EN=1 same stimulus -> three pulses.
REQ-033 SHALL verify E1,14,77,E1,F0,14,F0,77 -> pause_pulse once after final 77, no make/break/unknown pulses, held unchanged.
REQ-034 SHALL verify E0 then PREFIX_TIMEOUT idle cycles then 75 -> held[3]=0, unknown_pulse=1 (75 non-extended unmapped).
REQ-035 SHALL verify E0,FA,75 -> no pulses for FA, 75 decoded non-extended -> unknown_pulse; and 6B with rst=1 same cycle -> all outputs 0.
REQ-036 SHALL verify left+up held (E0,6B then E0,75) -> held=05h; E0,F0,6B -> held=01h, any_held=1.
